// File: rtl/button_event_decoder.sv
`default_nettype none
// ============================================================================
// Module   : button_event_decoder
// Purpose  : Classifies a debounced button level into one-cycle gesture
//            strobes (press, release, click, double click, long press) and a
//            held level.
// Revision : 1.0 - initial release
// ============================================================================
module button_event_decoder #(
   parameter int  SYSCLK_FREQ         = 24000000,
   parameter real LONG_PRESS_DELAY    = 0.500,
   parameter real DOUBLE_CLICK_WINDOW = 0.250
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic press_o,
   output logic release_o,
   output logic click_o,
   output logic dbl_click_o,
   output logic long_press_o,
   output logic held_o
);

   // Thresholds in clock cycles; both must be at least 2 because the sample
   // that enters a timed state is already counted as sample 1.
   localparam int LP_CYC  = $rtoi(SYSCLK_FREQ * LONG_PRESS_DELAY);
   localparam int DC_CYC  = $rtoi(SYSCLK_FREQ * DOUBLE_CLICK_WINDOW);
   localparam int MAX_CYC = (LP_CYC > DC_CYC) ? LP_CYC : DC_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   // cnt is zero on the second sample of a timed state, so the sample number
   // currently being evaluated is cnt + 2.
   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LP_CYC - 2);
   localparam logic [CNT_W-1:0] DC_LAST = CNT_W'(DC_CYC - 2);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PRESS1 = 3'd1,
      S_WAIT2  = 3'd2,
      S_PRESS2 = 3'd3,
      S_HELD   = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             d_q;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             click_q, click_d;
   logic             dbl_q, dbl_d;
   logic             long_q, long_d;
   logic             held_q, held_d;

   logic rise, fall, timed;

   // Next-state, counter and strobe decode; edges always win over thresholds.
   always_comb begin
      rise      = d_i & ~d_q;
      fall      = ~d_i & d_q;
      state_d   = state_q;
      press_d   = rise;
      release_d = fall;
      click_d   = 1'b0;
      dbl_d     = 1'b0;
      long_d    = 1'b0;
      timed     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (rise) begin
               state_d = S_PRESS1;
            end
         end
         S_PRESS1: begin
            timed = 1'b1;
            if (fall) begin
               state_d = S_WAIT2;
            end else if (d_i && (cnt_q == LP_LAST)) begin
               long_d  = 1'b1;
               state_d = S_HELD;
            end
         end
         S_WAIT2: begin
            timed = 1'b1;
            if (rise) begin
               state_d = S_PRESS2;
            end else if (!d_i && (cnt_q == DC_LAST)) begin
               click_d = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_PRESS2: begin
            if (fall) begin
               dbl_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_HELD: begin
            if (fall) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (timed && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = cnt_q;
      end

      held_d = (state_d == S_HELD);
   end

   // State, counter, input sample and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         d_q       <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         click_q   <= 1'b0;
         dbl_q     <= 1'b0;
         long_q    <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         d_q       <= d_i;
         press_q   <= press_d;
         release_q <= release_d;
         click_q   <= click_d;
         dbl_q     <= dbl_d;
         long_q    <= long_d;
         held_q    <= held_d;
      end
   end

   assign press_o      = press_q;
   assign release_o    = release_q;
   assign click_o      = click_q;
   assign dbl_click_o  = dbl_q;
   assign long_press_o = long_q;
   assign held_o       = held_q;

endmodule
`default_nettype wire

// File: tb/tb_button_event_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_event_decoder
// Purpose  : Self-checking bench for button_event_decoder with a gesture-level
//            reference model and directed plus randomized level patterns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_event_decoder;

   localparam int LP = 50;
   localparam int DC = 20;

   logic clk = 1'b0;
   logic rst;
   logic d;
   logic press_o, release_o, click_o, dbl_click_o, long_press_o, held_o;
   logic [5:0] obs_v;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: run length of the current level plus gesture flags.
   bit         m_prev;
   int         m_run;
   bit         m_first;    // first press in progress, long press still possible
   bit         m_pending;  // first press released, waiting for a second press
   bit         m_second;   // second press in progress
   bit         m_hold;     // long press reached, button still down
   logic [5:0] exp_v;      // {press, release, click, dbl, long, held}

   int c_press, c_release, c_click, c_dbl, c_long;
   bit pat[$];

   button_event_decoder #(
      .SYSCLK_FREQ        (1000000),
      .LONG_PRESS_DELAY   (0.000050),
      .DOUBLE_CLICK_WINDOW(0.000020)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .d_i         (d),
      .press_o     (press_o),
      .release_o   (release_o),
      .click_o     (click_o),
      .dbl_click_o (dbl_click_o),
      .long_press_o(long_press_o),
      .held_o      (held_o)
   );

   always #5 clk = ~clk;

   assign obs_v = {press_o, release_o, click_o, dbl_click_o, long_press_o, held_o};

   function automatic void model_reset();
      m_prev    = 1'b0;
      m_run     = 0;
      m_first   = 1'b0;
      m_pending = 1'b0;
      m_second  = 1'b0;
      m_hold    = 1'b0;
      exp_v     = 6'b0;
   endfunction

   function automatic void model_step(input bit dv);
      bit r, f, e_click, e_dbl, e_long;
      r       = dv & ~m_prev;
      f       = ~dv & m_prev;
      e_click = 1'b0;
      e_dbl   = 1'b0;
      e_long  = 1'b0;
      if (dv == m_prev) m_run = m_run + 1;
      else              m_run = 1;
      m_prev = dv;
      if (r) begin
         if (m_pending) begin
            m_pending = 1'b0;
            m_second  = 1'b1;
         end else begin
            m_first = 1'b1;
         end
      end else if (f) begin
         if (m_first) begin
            m_first   = 1'b0;
            m_pending = 1'b1;
         end else if (m_second) begin
            m_second = 1'b0;
            e_dbl    = 1'b1;
         end
         m_hold = 1'b0;
      end else if (dv) begin
         if (m_first && m_run == LP) begin
            m_first = 1'b0;
            m_hold  = 1'b1;
            e_long  = 1'b1;
         end
      end else begin
         if (m_pending && m_run == DC) begin
            m_pending = 1'b0;
            e_click   = 1'b1;
         end
      end
      exp_v = {r, f, e_click, e_dbl, e_long, m_hold};
   endfunction

   function automatic void add_run(input bit lvl, input int len);
      for (int i = 0; i < len; i++) pat.push_back(lvl);
   endfunction

   function automatic void clear_counts();
      c_press = 0; c_release = 0; c_click = 0; c_dbl = 0; c_long = 0;
   endfunction

   function automatic void count_events();
      c_press   += int'(press_o);
      c_release += int'(release_o);
      c_click   += int'(click_o);
      c_dbl     += int'(dbl_click_o);
      c_long    += int'(long_press_o);
   endfunction

   // Drive one sample, let the edge pass, advance the model.
   task automatic tick(input bit dv);
      d = dv;
      @(posedge clk);
      #1;
      if (rst) model_reset();
      else     model_step(dv);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      d   = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         tick(1'(i));
         n_checks++;
         if (obs_v !== 6'b0) begin
            n_fail++;
            $display("FAIL reset cyc %0d: outputs %b, required 000000", i, obs_v);
         end
      end
      d   = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(1'b0);
         n_checks++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL reset_idle cyc %0d: outputs %b, required %b", i, obs_v, exp_v);
         end
      end
   endtask

   task automatic test_single_click();
      pat.delete();
      add_run(1'b1, 10);
      add_run(1'b0, 30);
      clear_counts();
      foreach (pat[i]) begin
         tick(pat[i]);
         count_events();
         n_checks++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL single_click cyc %0d: outputs %b, required %b", i, obs_v, exp_v);
         end
      end
      n_checks++;
      if ({c_press, c_release, c_click, c_dbl, c_long} !== {32'd1, 32'd1, 32'd1, 32'd0, 32'd0}) begin
         n_fail++;
         $display("FAIL single_click_counts: p/r/c/d/l %0d %0d %0d %0d %0d, required 1 1 1 0 0",
                  c_press, c_release, c_click, c_dbl, c_long);
      end
   endtask

   task automatic test_double_click();
      pat.delete();
      add_run(1'b1, 10);
      add_run(1'b0, 5);
      add_run(1'b1, 10);
      add_run(1'b0, 30);
      clear_counts();
      foreach (pat[i]) begin
         tick(pat[i]);
         count_events();
         n_checks++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL double_click cyc %0d: outputs %b, required %b", i, obs_v, exp_v);
         end
      end
      n_checks++;
      if ({c_press, c_release, c_click, c_dbl, c_long} !== {32'd2, 32'd2, 32'd0, 32'd1, 32'd0}) begin
         n_fail++;
         $display("FAIL double_click_counts: p/r/c/d/l %0d %0d %0d %0d %0d, required 2 2 0 1 0",
                  c_press, c_release, c_click, c_dbl, c_long);
      end
   endtask

   task automatic test_long_press_boundary();
      pat.delete();
      add_run(1'b1, LP - 1);
      add_run(1'b0, 30);
      add_run(1'b1, LP);
      add_run(1'b1, 7);
      add_run(1'b0, 30);
      clear_counts();
      foreach (pat[i]) begin
         tick(pat[i]);
         count_events();
         n_checks++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL long_press cyc %0d: outputs %b, required %b", i, obs_v, exp_v);
         end
      end
      n_checks++;
      if ({c_click, c_long} !== {32'd1, 32'd1}) begin
         n_fail++;
         $display("FAIL long_press_counts: click %0d long %0d, required 1 1", c_click, c_long);
      end
   endtask

   task automatic test_late_second_press();
      pat.delete();
      add_run(1'b1, 10);
      add_run(1'b0, DC - 1);
      add_run(1'b1, 8);
      add_run(1'b0, 30);
      clear_counts();
      foreach (pat[i]) begin
         tick(pat[i]);
         count_events();
         n_checks++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL late_second cyc %0d: outputs %b, required %b", i, obs_v, exp_v);
         end
      end
      n_checks++;
      if ({c_click, c_dbl} !== {32'd0, 32'd1}) begin
         n_fail++;
         $display("FAIL late_second_counts: click %0d dbl %0d, required 0 1", c_click, c_dbl);
      end
   endtask

   task automatic test_reset_mid_press();
      clear_counts();
      for (int i = 0; i < 30; i++) begin
         tick(1'b1);
         n_checks++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL rst_mid_pre cyc %0d: outputs %b, required %b", i, obs_v, exp_v);
         end
      end
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      n_checks++;
      if (obs_v !== 6'b0) begin
         n_fail++;
         $display("FAIL rst_mid_async: outputs %b, required 000000", obs_v);
      end
      for (int i = 0; i < 3; i++) begin
         tick(1'b1);
         n_checks++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL rst_mid_hold cyc %0d: outputs %b, required %b", i, obs_v, exp_v);
         end
      end
      rst = 1'b0;
      pat.delete();
      add_run(1'b1, LP + 5);
      add_run(1'b0, 30);
      foreach (pat[i]) begin
         tick(pat[i]);
         count_events();
         n_checks++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL rst_mid_post cyc %0d: outputs %b, required %b", i, obs_v, exp_v);
         end
      end
      n_checks++;
      if ({c_press, c_long, c_click} !== {32'd1, 32'd1, 32'd0}) begin
         n_fail++;
         $display("FAIL rst_mid_counts: press %0d long %0d click %0d, required 1 1 0",
                  c_press, c_long, c_click);
      end
   endtask

   task automatic test_back_to_back();
      rst = 1'b1;
      d   = 1'b1;
      @(posedge clk);
      #3;
      rst = 1'b0;
      model_reset();
      pat.delete();
      add_run(1'b1, 5);
      add_run(1'b0, 5);
      add_run(1'b1, 5);
      add_run(1'b0, 5);
      add_run(1'b1, 5);
      add_run(1'b0, 30);
      clear_counts();
      foreach (pat[i]) begin
         tick(pat[i]);
         count_events();
         n_checks++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL back_to_back cyc %0d: outputs %b, required %b", i, obs_v, exp_v);
         end
      end
      n_checks++;
      if ({c_press, c_dbl, c_click} !== {32'd3, 32'd1, 32'd1}) begin
         n_fail++;
         $display("FAIL back_to_back_counts: press %0d dbl %0d click %0d, required 3 1 1",
                  c_press, c_dbl, c_click);
      end
   endtask

   function automatic int pick_len(input int thr);
      case ($urandom_range(0, 3))
         0:       return int'($urandom_range(1, 6));
         1:       return thr - 1 + int'($urandom_range(0, 2));
         2:       return int'($urandom_range(1, thr + 10));
         default: return int'($urandom_range(7, thr - 2));
      endcase
   endfunction

   task automatic test_random();
      pat.delete();
      for (int g = 0; g < 40; g++) begin
         add_run(1'b1, pick_len(LP));
         add_run(1'b0, pick_len(DC));
      end
      add_run(1'b0, 30);
      foreach (pat[i]) begin
         tick(pat[i]);
         n_checks++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL random cyc %0d: outputs %b, required %b", i, obs_v, exp_v);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      d   = 1'b0;
      test_reset();
      test_single_click();
      test_double_click();
      test_long_press_boundary();
      test_late_second_press();
      test_reset_mid_press();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
